// File: rtl/mem_access_stage.sv
// MEM pipeline stage: multi-cycle loads/stores against a word memory, stalling upstream meanwhile.
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        memRead_in,
    input  logic        memWrite_in,
    input  logic        memToReg_in,
    input  logic        regShouldWrite_in,
    input  logic [32:1] aluOut_in,
    input  logic [32:1] regReadData2_in,
    input  logic [5:1]  regWriteAddress_in,
    output logic        stall_out,
    output logic        regShouldWrite_out,
    output logic [5:1]  regWriteAddress_out,
    output logic [32:1] regWriteData_out,
    output logic        misalign_out
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [32:1]           alu_q;
    logic [32:1]           wdata_q;
    logic [32:1]           rdata_q;
    logic [5:1]            waddr_q;
    logic                  mtr_q;
    logic                  rsw_q;
    logic                  store_q;

    logic [32:1] mem_q [0:(1 << DEPTH_LOG2) - 1];

    logic mem_op;
    logic misalign;
    logic access;

    assign mem_op = memRead_in | memWrite_in;
    assign access = (state_q == StBusy) && (cnt_q == 4'd0);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_op & (aluOut_in[2:1] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Stall is raised combinationally on acceptance so upstream holds the op in place.
    assign stall_out = (state_q == StBusy) ||
                       ((state_q == StIdle) && mem_op && !misalign);

    // Memory is not reset; an async reset clears state_q so a pending store never lands.
    always_ff @(posedge CLK) begin
        if (access && store_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q             <= StIdle;
            cnt_q               <= 4'd0;
            idx_q               <= '0;
            alu_q               <= '0;
            wdata_q             <= '0;
            rdata_q             <= '0;
            waddr_q             <= '0;
            mtr_q               <= 1'b0;
            rsw_q               <= 1'b0;
            store_q             <= 1'b0;
            regShouldWrite_out  <= 1'b0;
            regWriteAddress_out <= '0;
            regWriteData_out    <= '0;
            misalign_out        <= 1'b0;
        end else begin
            misalign_out <= 1'b0;
            case (state_q)
                StIdle: begin
                    regWriteAddress_out <= regWriteAddress_in;
                    regWriteData_out    <= aluOut_in;
                    if (misalign) begin
                        misalign_out       <= 1'b1;
                        regShouldWrite_out <= 1'b0;
                    end else if (mem_op) begin
                        idx_q              <= aluOut_in[DEPTH_LOG2+2:3];
                        alu_q              <= aluOut_in;
                        wdata_q            <= regReadData2_in;
                        waddr_q            <= regWriteAddress_in;
                        mtr_q              <= memToReg_in;
                        rsw_q              <= regShouldWrite_in;
                        store_q            <= memWrite_in;
                        cnt_q              <= 4'(LATENCY - 1);
                        regShouldWrite_out <= 1'b0;
                        state_q            <= StBusy;
                    end else begin
                        regShouldWrite_out <= regShouldWrite_in;
                    end
                end
                StBusy: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        if (!store_q) begin
                            rdata_q <= mem_q[idx_q];
                        end
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Inputs still show the finished op here; they are deliberately ignored.
                    regShouldWrite_out  <= rsw_q & ~store_q;
                    regWriteAddress_out <= waddr_q;
                    regWriteData_out    <= mtr_q ? rdata_q : alu_q;
                    state_q             <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed scoreboard bench for mem_access_stage (DEPTH_LOG2=8, LATENCY=2).
module tb_mem_access_stage;

    localparam int unsigned Lat = 2;
    localparam int unsigned Dl  = 8;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        memRead_in, memWrite_in, memToReg_in, regShouldWrite_in;
    logic [32:1] aluOut_in, regReadData2_in;
    logic [5:1]  regWriteAddress_in;
    logic        stall_out, regShouldWrite_out, misalign_out;
    logic [5:1]  regWriteAddress_out;
    logic [32:1] regWriteData_out;

    mem_access_stage #(.DEPTH_LOG2(Dl), .LATENCY(Lat)) dut (
        .CLK                (CLK),
        .Reset              (Reset),
        .memRead_in         (memRead_in),
        .memWrite_in        (memWrite_in),
        .memToReg_in        (memToReg_in),
        .regShouldWrite_in  (regShouldWrite_in),
        .aluOut_in          (aluOut_in),
        .regReadData2_in    (regReadData2_in),
        .regWriteAddress_in (regWriteAddress_in),
        .stall_out          (stall_out),
        .regShouldWrite_out (regShouldWrite_out),
        .regWriteAddress_out(regWriteAddress_out),
        .regWriteData_out   (regWriteData_out),
        .misalign_out       (misalign_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rsw;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_data;
        logic        chk_addr;
        logic        mis;
        int          cycles;
        int          stalls;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        memRead_in         = 1'b0;
        memWrite_in        = 1'b0;
        memToReg_in        = 1'b0;
        regShouldWrite_in  = 1'b0;
        aluOut_in          = '0;
        regReadData2_in    = '0;
        regWriteAddress_in = '0;
    endtask

    // Called #1 after a rising edge with the FSM idle; returns #1 after the WB edge.
    task automatic run_op(input string tag, input logic rd, input logic wr, input logic mtr,
                          input logic rsw, input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] wa);
        exp_t e;
        int   word;
        logic mem;
        logic mis;
        int   cycles;
        int   stalls;
        logic done;
        logic s;
        mem  = rd | wr;
        word = int'((addr >> 2) & ((32'd1 << Dl) - 1));
`ifdef MEM_ALIGN_CHECK_EN
        mis = mem && (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        e.mis      = mis;
        e.addr     = wa;
        e.chk_addr = !mis;
        if (mis) begin
            e.rsw = 1'b0; e.data = '0; e.chk_data = 1'b0; e.cycles = 1; e.stalls = 0;
        end else if (!mem) begin
            e.rsw = rsw; e.data = addr; e.chk_data = 1'b1; e.cycles = 1; e.stalls = 0;
        end else if (wr) begin
            e.rsw = 1'b0; e.data = '0; e.chk_data = 1'b0;
            e.cycles = Lat + 2; e.stalls = Lat + 1;
            model[word] = data;
        end else begin
            e.rsw = rsw; e.chk_data = 1'b1;
            e.data = mtr ? model[word] : addr;
            e.cycles = Lat + 2; e.stalls = Lat + 1;
        end
        sb.push_back(e);

        memRead_in = rd; memWrite_in = wr; memToReg_in = mtr; regShouldWrite_in = rsw;
        aluOut_in = addr; regReadData2_in = data; regWriteAddress_in = wa;
        cycles = 0; stalls = 0; done = 1'b0;
        while (!done && cycles < 20) begin
            @(negedge CLK);
            s = stall_out;
            if (s) stalls++;
            if (s && cycles > 0) chk({tag, " busy bubble"}, 32'(regShouldWrite_out), 32'd0);
            @(posedge CLK);
            #1;
            cycles++;
            if (!s) done = 1'b1;
        end
        drive_idle();
        chk({tag, " completed"}, 32'(done), 32'd1);

        e = sb.pop_front();
        chk({tag, " cycles"}, 32'(cycles), 32'(e.cycles));
        chk({tag, " stalls"}, 32'(stalls), 32'(e.stalls));
        chk({tag, " wb_en"}, 32'(regShouldWrite_out), 32'(e.rsw));
        chk({tag, " misalign"}, 32'(misalign_out), 32'(e.mis));
        if (e.chk_addr) chk({tag, " wb_addr"}, 32'(regWriteAddress_out), 32'(e.addr));
        if (e.chk_data) chk({tag, " wb_data"}, regWriteData_out, e.data);
        if (e.mis) begin
            @(posedge CLK);
            #1;
            chk({tag, " misalign clears"}, 32'(misalign_out), 32'd0);
        end
    endtask

    initial begin
        Reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge CLK);
        #1;
        chk("reset stall", 32'(stall_out), 32'd0);
        chk("reset wb_en", 32'(regShouldWrite_out), 32'd0);
        chk("reset wb_addr", 32'(regWriteAddress_out), 32'd0);
        chk("reset wb_data", regWriteData_out, 32'd0);
        chk("reset misalign", 32'(misalign_out), 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;

        run_op("alu r3", 1'b0, 1'b0, 1'b0, 1'b1, 32'h7, 32'h0, 5'd3);
        run_op("alu nowr", 1'b0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd9);
        run_op("store 40", 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h12345678, 5'd0);
        run_op("load 40", 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd5);
        run_op("store 400", 1'b0, 1'b1, 1'b0, 1'b0, 32'h400, 32'hA5A5A5A5, 5'd0);
        run_op("load 000", 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0, 5'd6);
        run_op("rd+wr 8", 1'b1, 1'b1, 1'b1, 1'b1, 32'h8, 32'h55, 5'd12);
        run_op("load 8", 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'h0, 5'd7);
        run_op("load alu", 1'b1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h0, 5'd8);
        run_op("store 10", 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hCAFEF00D, 5'd0);

        // Store aborted by reset in its second BUSY cycle; model is left untouched.
        memWrite_in = 1'b1; aluOut_in = 32'h10; regReadData2_in = 32'hDEADBEEF;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("abort in busy", 32'(stall_out), 32'd1);
        #2;
        Reset = 1'b1;
        drive_idle();
        #1;
        chk("abort stall", 32'(stall_out), 32'd0);
        chk("abort wb_en", 32'(regShouldWrite_out), 32'd0);
        chk("abort wb_addr", 32'(regWriteAddress_out), 32'd0);
        chk("abort wb_data", regWriteData_out, 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        run_op("load 10", 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'h0, 5'd2);

        run_op("load 42", 1'b1, 1'b0, 1'b1, 1'b1, 32'h42, 32'h0, 5'd4);
        run_op("store 43", 1'b0, 1'b1, 1'b0, 1'b0, 32'h43, 32'h0BADF00D, 5'd0);
        run_op("load 40 again", 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd1);
        run_op("alu back", 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF0001, 32'h0, 5'd31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
